dram_sipo: RTL and testbench
============================

Name: dram_sipo

Overview:
- Serial-in/parallel-out deserializer on the DRAM data return path; consumes the LSB-first serial stream produced by the controller's PISO serializer.
- Rebuilds WIDTH-bit words, frames them with a start strobe aligned to the serializer's load, and presents each word on a valid/ready output.
- One-word output holding register with sticky overrun detection.

Parameters:
- WIDTH, 8, word width in bits (>=2); the bit counter is $clog2(WIDTH+1) bits wide.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset: one clock; reset is asynchronous and active-high
- start  input  1  frame strobe; driven in the same cycle as the serializer's load
- data_in  input  1  serial data, LSB first
- ovr_clr  input  1  clears the overrun flag
- out_ready  input  1  downstream accepts word
- out_valid  output  1  word available in the holding register
- out_data  output  WIDTH  received word
- busy  output  1  high while in RECV
- overrun  output  1  sticky: a completed word was dropped
- parity_err  output  1  see Optional Feature; constant 0 when the feature is compiled out

Behaviour:
- Reset (async, rst=1): state=IDLE, bit count=0, shift reg=0, out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0.
- FSM states:
  - IDLE: start=1 sampled at edge E -> RECV with count=0.
  - RECV: samples data_in on edges E+1..E+NB, where NB=WIDTH, or WIDTH+1 with parity enabled.
  - Shift rule: shreg <= {data_in, shreg[WIDTH-1:1]} for data bits; count increments per sampled bit.
  - Final bit edge (count==NB-1): word completes, state -> IDLE, unless start=1 on that same edge (see below).
  - busy = (state==RECV).
- Word completion at edge E+NB:
  - The completed word is {data_in, shreg[WIDTH-1:1]}; with parity enabled, the word is the shreg contents and data_in is the parity bit.
  - Holding register free (out_valid=0), or popped on the same edge (out_valid & out_ready): load out_data, out_valid=1. Latency: out_valid rises one edge after bit WIDTH-1 is on data_in.
  - Holding register full and not popped: the new word is dropped, out_data is unchanged, overrun <= 1.
- Output handshake:
  - Transfer occurs on an edge with out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - After a pop with no completion on that edge, out_valid=0.
  - out_ready is ignored while out_valid=0.
- start while in RECV (count < NB-1): the partial word is discarded, count -> 0, and reception restarts. No flag is raised.
- start on the final-bit edge: the word completes normally, and the FSM stays in RECV with count=0 for the new frame. This supports back-to-back frames with no gap.
- start in IDLE while data_in toggles: data_in is ignored outside RECV.
- ovr_clr:
  - Clears overrun on the next edge.
  - If an overrun event occurs on the same edge, set wins (overrun stays 1).
- Reset asserted mid-frame: all state returns to reset values immediately; the partial word and the held word are lost.

Optional Feature:
- Macro: DRAM_SIPO_PARITY_EN.
- Defined:
  - NB=WIDTH+1; the extra bit after the MSB is even parity over the data bits.
  - On completion, parity_err <= (^word ^ parity_bit) when the word is loaded.
  - parity_err is valid alongside out_valid and cleared on pop.
  - A dropped (overrun) word does not update parity_err.
- Not defined: NB=WIDTH, parity_err tied to 0, no parity logic.

Test Plan (WIDTH=8, feature off unless noted):
- Single word:
  - Stimulus: start at edge 0; data_in bits 1,0,1,0,0,1,0,1 sampled at edges 1..8; out_ready=1.
  - Response: out_valid=1 after edge 8 with out_data=8'hA5; busy high during edges 1..8; out_valid drops after edge 9.
- Back-to-back:
  - Stimulus: 0x3C then 0xC3, with the second start on the first word's edge 8; out_ready=1.
  - Response: 0x3C valid after edge 8; 0xC3 valid after edge 16; busy never deasserts between frames.
- Backpressure/overrun:
  - Stimulus: out_ready=0; send 0x11 then 0x22.
  - Response: out_data stays 0x11; overrun=1 after the second frame completes.
  - Continuation: pulse ovr_clr -> overrun=0; raise out_ready -> 0x11 popped, out_valid=0.
- Abort/restart:
  - Stimulus: start, 4 bits of 0xFF, start again, then full 0x5A.
  - Response: exactly one word, 0x5A; no overrun.
- Async reset mid-frame:
  - Stimulus: assert rst between edges 3 and 4 of a frame, with a held word present.
  - Response: out_valid, busy, out_data, overrun go to 0 without a clock edge; a following frame 0x81 is received correctly.
- Parity (DRAM_SIPO_PARITY_EN):
  - Stimulus: 0xA5 with parity bit 0.
  - Response: out_data=0xA5, parity_err=0.
  - Stimulus: 0xA5 with parity bit 1.
  - Response: parity_err=1 while out_valid, cleared on pop.

Source files
------------

// File: rtl/dram_sipo.sv
// dram_sipo: serial-in/parallel-out deserializer for the DRAM data return path.
// Takes the LSB-first stream from the controller's PISO serializer. Each frame
// begins with a start strobe in the same cycle as the serializer's load. The
// word is rebuilt and presented on a one-word valid/ready holding register.
// A word that completes while the holding register is still full is dropped,
// and the sticky overrun flag is raised.
//
// Optional feature macro: DRAM_SIPO_PARITY_EN
//   defined   : each frame carries one extra even-parity bit after the MSB;
//               parity_err is reported alongside the held word.
//   undefined : frames are WIDTH bits long and parity_err is tied to 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start strobe; data_in is ignored
// RECV  | sampling one serial bit per clock until the frame completes

module dram_sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_in,
    input  logic             ovr_clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef DRAM_SIPO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             pop;
    logic             load;
    logic             drop;

    // With parity the data bits are already aligned in the shift register when
    // the parity bit arrives; without it the MSB is still on data_in.
`ifdef DRAM_SIPO_PARITY_EN
    assign word = shreg_q;
`else
    assign word = {data_in, shreg_q[WIDTH-1:1]};
`endif

    // State register and receive datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state, bit counter and shift logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (cnt_q == CNT_LAST) begin
                    // Final bit always completes the word; a coincident start
                    // opens the next frame with no gap.
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = start ? RECV : IDLE;
`ifndef DRAM_SIPO_PARITY_EN
                    shreg_d   = word;
`endif
                end else if (start) begin
                    // Restart: the partial word is silently abandoned.
                    cnt_d = '0;
                end else begin
                    shreg_d = {data_in, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register, handshake and overrun decisions
    always_comb begin
        pop     = valid_q & out_ready;
        load    = word_done & (~valid_q | pop);
        drop    = word_done & valid_q & ~out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = word;
        end else if (pop) begin
            valid_d = 1'b0;
        end
        // Set has priority over clear when both land on the same edge.
        ovr_d = (ovr_q & ~ovr_clr) | drop;
    end

    // Output holding register and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef DRAM_SIPO_PARITY_EN
    logic perr_q, perr_d;

    // Parity status follows the held word: set on load, cleared on pop,
    // untouched when a word is dropped.
    always_comb begin
        perr_d = perr_q;
        if (load) begin
            perr_d = (^word) ^ data_in;
        end else if (pop) begin
            perr_d = 1'b0;
        end
    end

    // Parity error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q == RECV);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_dram_sipo.sv
// Bench for dram_sipo (WIDTH=8). A frame-level reference model (list of bits
// received since the last start, plus the held word) predicts every output
// after every clock edge; directed scenarios add explicit expected constants.
`timescale 1ns/1ps

module tb_dram_sipo;

    localparam int W = 8;
`ifdef DRAM_SIPO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         data_in;
    logic         ovr_clr;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit           m_in_frame;
    bit           m_bits[$];
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_ovr;
    bit           m_perr;

    dram_sipo #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ovr_clr    (ovr_clr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_bits.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endfunction

    // One clock edge of the frame-level model.
    function automatic void model_step(bit s, bit d, bit r, bit c);
        bit           done = 1'b0;
        bit           pop;
        bit           drop = 1'b0;
        bit           pbit = 1'b0;
        logic [W-1:0] w    = '0;
        pop = m_valid && r;
        if (m_in_frame) begin
            if (s && m_bits.size() < NB - 1) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == NB) begin
                    for (int i = 0; i < W; i++) w[i] = m_bits[i];
`ifdef DRAM_SIPO_PARITY_EN
                    pbit = m_bits[W];
`endif
                    done = 1'b1;
                    m_bits.delete();
                    m_in_frame = s;
                end
            end
        end else if (s) begin
            m_in_frame = 1'b1;
            m_bits.delete();
        end
        if (done && (!m_valid || pop)) begin
            m_valid = 1'b1;
            m_data  = w;
`ifdef DRAM_SIPO_PARITY_EN
            m_perr  = (($countones(w) + int'(pbit)) % 2) != 0;
`endif
        end else begin
            if (done) drop = 1'b1;
            if (pop) begin
                m_valid = 1'b0;
                m_perr  = 1'b0;
            end
        end
        m_ovr = (m_ovr && !c) || drop;
    endfunction

    task automatic check_outputs();
        check_val("out_valid", 32'(out_valid), 32'(m_valid));
        check_val("out_data", 32'(out_data), 32'(m_data));
        check_val("busy", 32'(busy), 32'(m_in_frame));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        check_val("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    // Drive inputs (caller is away from the edge), take one edge, then compare.
    task automatic tick(input bit s, input bit d, input bit r, input bit c);
        start     = s;
        data_in   = d;
        out_ready = r;
        ovr_clr   = c;
        @(posedge clk);
        model_step(s, d, r, c);
        #1;
        check_outputs();
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit pbit, input bit rdy,
                              input bit lead_start, input bit last_start);
        if (lead_start) tick(1'b1, 1'b0, rdy, 1'b0);
        for (int i = 0; i < W; i++) begin
            tick((i == W - 1 && NB == W) ? last_start : 1'b0, w[i], rdy, 1'b0);
        end
`ifdef DRAM_SIPO_PARITY_EN
        tick(last_start, pbit, rdy, 1'b0);
`else
        if (pbit) begin end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        data_in   = 1'b0;
        ovr_clr   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        check_val("rst_perr", 32'(parity_err), 32'd0);
        #11;
        rst = 1'b0;

        // single word
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("single_busy", 32'(busy), 32'd1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("single_valid", 32'(out_valid), 32'd1);
        check_val("single_data", 32'(out_data), 32'hA5);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("single_drop_valid", 32'(out_valid), 32'd0);

        // back-to-back frames
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("b2b_first", 32'(out_data), 32'h3C);
        check_val("b2b_busy", 32'(busy), 32'd1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("b2b_second", 32'(out_data), 32'hC3);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // backpressure and overrun
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("bp_data", 32'(out_data), 32'h11);
        check_val("bp_ovr", 32'(overrun), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("ovr_clr", 32'(overrun), 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("bp_pop_valid", 32'(out_valid), 32'd0);

        // abort and restart
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("abort_data", 32'(out_data), 32'h5A);
        check_val("abort_ovr", 32'(overrun), 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("abort_one_word", 32'(out_valid), 32'd0);

        // async reset mid-frame with a held word
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_data", 32'(out_data), 32'd0);
        check_val("arst_ovr", 32'(overrun), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("arst_next_frame", 32'(out_data), 32'h81);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DRAM_SIPO_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("par_ok_data", 32'(out_data), 32'hA5);
        check_val("par_ok_err", 32'(parity_err), 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("par_bad_err", 32'(parity_err), 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("par_pop_clear", 32'(parity_err), 32'd0);
`endif

        // random whole frames, some back-to-back
        for (int f = 0; f < 150; f++) begin
            logic [W-1:0] rw;
            rw = W'($urandom);
            send_frame(rw, 1'($urandom), 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) tick(1'b0, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        // random cycle-level stimulus, including aborts and ovr_clr races
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
